// File: rtl/apb_vic.sv
// APB vectored interrupt controller with an xps_intc-style register map.
// Adds per-source level/edge trigger, polarity, software-set pending and a registered vector.
module apb_vic #(
  parameter int                 NR_IRQS     = 8,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [NR_IRQS-1:0] EDGE_RST    = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               PENABLE,
  input  logic               PSEL,
  input  logic               PWRITE,
  input  logic [31:0]        PWDATA,
  input  logic [5:0]         PADDR,
  output logic [31:0]        PRDATA,
  input  logic [NR_IRQS-1:0] irqs,
  output logic               irq_out
);

  localparam logic [5:0] A_ISR  = 6'h00;
  localparam logic [5:0] A_IPR  = 6'h04;
  localparam logic [5:0] A_IER  = 6'h08;
  localparam logic [5:0] A_IAR  = 6'h0c;
  localparam logic [5:0] A_SIE  = 6'h10;
  localparam logic [5:0] A_CIE  = 6'h14;
  localparam logic [5:0] A_IVR  = 6'h18;
  localparam logic [5:0] A_MER  = 6'h1c;
  localparam logic [5:0] A_EDGE = 6'h20;
  localparam logic [5:0] A_POL  = 6'h24;

  logic [NR_IRQS-1:0] sync_q [SYNC_STAGES];
  logic [NR_IRQS-1:0] sync_d [SYNC_STAGES];
  logic [NR_IRQS-1:0] p_last_q, p_last_d;
  logic [NR_IRQS-1:0] pend_q, pend_d;
  logic [NR_IRQS-1:0] ier_q, ier_d;
  logic [NR_IRQS-1:0] pol_q, pol_d;
  logic [NR_IRQS-1:0] edge_q, edge_d;
  logic [1:0]         mer_q, mer_d;
  logic [31:0]        vector_q, vector_d;
  logic               irq_out_q, irq_out_d;

  logic [NR_IRQS-1:0] p_s, isr_s, ipr_s, rise_s, wdata_s;
  logic               wr_s;
  logic               unused_s;

  function automatic logic [31:0] lowest_set(input logic [NR_IRQS-1:0] v);
    logic [31:0] idx;
    idx = 32'hffff_ffff;
    for (int i = NR_IRQS - 1; i >= 0; i--) begin
      if (v[i]) idx = 32'(i);
    end
    return idx;
  endfunction

  assign wdata_s  = PWDATA[NR_IRQS-1:0];
  assign unused_s = ^PWDATA;
  assign irq_out  = irq_out_q;

  // Trigger qualification, register writes and next-state for every flop.
  always_comb begin
    wr_s   = PSEL & PENABLE & PWRITE;
    p_s    = sync_q[SYNC_STAGES-1] ^ pol_q;
    isr_s  = pend_q | (p_s & ~edge_q);
    ipr_s  = isr_s & ier_q;
    rise_s = p_s & ~p_last_q & edge_q;

    sync_d[0] = irqs;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    p_last_d = p_s;

    pend_d = pend_q;
    ier_d  = ier_q;
    pol_d  = pol_q;
    edge_d = edge_q;
    mer_d  = mer_q;
    if (wr_s) begin
      case (PADDR)
        A_ISR:   pend_d = mer_q[1] ? pend_q : (pend_q | wdata_s);
        A_IAR:   pend_d = pend_q & ~wdata_s;
        A_IER:   ier_d  = wdata_s;
        A_SIE:   ier_d  = ier_q | wdata_s;
        A_CIE:   ier_d  = ier_q & ~wdata_s;
        A_MER:   mer_d  = PWDATA[1:0];
        A_EDGE:  edge_d = wdata_s;
        A_POL:   pol_d  = wdata_s;
        default: pend_d = pend_q;
      endcase
    end else begin
      pend_d = pend_q;
    end
    // A fresh edge wins over an acknowledge landing in the same cycle.
    pend_d = pend_d | rise_s;

    irq_out_d = (|ipr_s) & mer_q[0];
    vector_d  = lowest_set(ipr_s);
  end

  // Combinational read mux, zero-wait-state.
  always_comb begin
    case (PADDR)
      A_ISR:   PRDATA = 32'(isr_s);
      A_IPR:   PRDATA = 32'(ipr_s);
      A_IER:   PRDATA = 32'(ier_q);
      A_IVR:   PRDATA = vector_q;
      A_MER:   PRDATA = {30'd0, mer_q};
      A_EDGE:  PRDATA = 32'(edge_q);
      A_POL:   PRDATA = 32'(pol_q);
      default: PRDATA = 32'd0;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      p_last_q  <= '0;
      pend_q    <= '0;
      ier_q     <= '0;
      pol_q     <= '0;
      edge_q    <= EDGE_RST;
      mer_q     <= 2'b00;
      vector_q  <= 32'hffff_ffff;
      irq_out_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      p_last_q  <= p_last_d;
      pend_q    <= pend_d;
      ier_q     <= ier_d;
      pol_q     <= pol_d;
      edge_q    <= edge_d;
      mer_q     <= mer_d;
      vector_q  <= vector_d;
      irq_out_q <= irq_out_d;
    end
  end

endmodule
